multi_clock_nco: RTL
====================

MULTI_CLOCK_NCO -- requirements
Module: multi_clock_nco

Interface
REQ-001 The block SHALL expose parameter CHANNELS, default 2: number of independent clock outputs, 1..8.
REQ-002 The block SHALL expose parameter ACC_WIDTH, default 24: phase accumulator and increment width in bits, 4..32.
REQ-003 The block SHALL expose parameter LOCK_CYCLES, default 16: settle count before locked asserts, 1..2^16.
REQ-004 The block SHALL expose parameter INC_INIT, default all-zero, width CHANNELS*ACC_WIDTH: per-channel reset increments, channel 0 in the LSBs.
REQ-005 Port clock_in, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port incr_load, input, 1 bit: one-cycle request to load a new increment.
REQ-008 Port incr_chan, input, clog2(CHANNELS) bits (min 1): target channel for incr_load.
REQ-009 Port incr_value, input, ACC_WIDTH bits: new increment for incr_load.
REQ-010 Port phase_sync, input, 1 bit: one-cycle request to zero all accumulators.
REQ-011 Port clock_out, output, CHANNELS bits: registered accumulator MSB per channel, the generated clock.
REQ-012 Port clock_en, output, CHANNELS bits: one-cycle strobe per accumulator wrap.
REQ-013 Port locked, output, 1 bit: outputs stable and configuration unchanged for LOCK_CYCLES.

Function
REQ-014 Each cycle, each channel SHALL compute acc_next = (acc + inc) mod 2^ACC_WIDTH; the carry out SHALL be the wrap flag.
REQ-015 clock_en[i] SHALL be the registered wrap flag: high for exactly the cycle after the wrapping update.
REQ-016 clock_out[i] SHALL be the registered MSB of acc_next, so output frequency = f_clock_in*inc/2^ACC_WIDTH.
REQ-017 A channel with inc = 0 SHALL hold its accumulator, clock_en[i] SHALL stay 0, and clock_out[i] SHALL hold its value.
REQ-018 incr_load with incr_chan < CHANNELS SHALL replace inc of that channel at the clock edge; the first accumulation with the new value SHALL occur on the following edge.
REQ-019 incr_load with incr_chan >= CHANNELS SHALL be ignored entirely: no increment change and no lock drop.
REQ-020 phase_sync SHALL load 0 into every accumulator in place of acc_next at that edge; clock_out and clock_en SHALL be 0 in the following cycle.
REQ-021 phase_sync and a valid incr_load in the same cycle SHALL both take effect: accumulators are zeroed and the new inc is used from the next edge.
REQ-022 Lock FSM states SHALL be: RESET -> SETTLE (unconditional, next edge), SETTLE -> LOCKED after LOCK_CYCLES consecutive SETTLE cycles, and LOCKED -> SETTLE on any valid incr_load or any phase_sync.
REQ-023 In SETTLE, a valid incr_load or a phase_sync SHALL restart the settle counter from 0.
REQ-024 locked SHALL be 1 only in LOCKED and SHALL be a registered output, deasserting in the cycle after the triggering request.
REQ-025 The settle counter SHALL saturate and SHALL not wrap; its width SHALL be clog2(LOCK_CYCLES+1).
REQ-026 Behaviour of locked SHALL be independent of whether any inc is 0.

Reset
REQ-027 While reset_n = 0, all accumulators, clock_out, clock_en, the settle counter, and locked SHALL be 0, inc[i] SHALL equal INC_INIT slice i, and the FSM SHALL be in RESET, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL take effect immediately (asynchronously); release SHALL be treated synchronously, with the first accumulation on the first edge after release.
REQ-029 locked SHALL first assert LOCK_CYCLES+1 edges after reset release when no requests are received.

Verification
REQ-030 ACC_WIDTH=8, inc0=0x40, reset released -> clock_en[0] pulses every 4 cycles; clock_out[0] pattern is 0,0,1,1 repeating (2 high, 2 low).
REQ-031 inc1=0x80 with inc0=0x40 -> clock_out[1] toggles every cycle; clock_en[1] pulses every 2 cycles; the channels are independent.
REQ-032 LOCK_CYCLES=16, no stimulus -> locked rises on the 17th edge after release; incr_load chan 0 value 0x20 while locked -> locked=0 next cycle, re-asserts 16 cycles later, and clock_en[0] period becomes 8.
REQ-033 incr_load with incr_chan=3 while CHANNELS=2 -> no output change; locked stays 1.
REQ-034 phase_sync and incr_load asserted together mid-period -> all clock_out=0 next cycle, the new rate applies from the following edge, and the lock counter restarts.
REQ-035 reset_n pulsed low for half a cycle mid-stream -> all outputs 0 without a clock edge; the sequence after release is identical to a power-on reset.

Source files
------------

// File: rtl/multi_clock_nco.sv
// multi_clock_nco
// ---------------
// Bank of independent numerically controlled oscillators sharing one input
// clock. Each channel adds its increment to a phase accumulator every cycle;
// the registered accumulator MSB is the generated clock and the registered
// carry is a one-cycle enable strobe per wrap. A small lock FSM reports when
// the configuration has been left untouched long enough for the outputs to be
// considered stable.
//
// Ports
//   clock_in    : single clock, all logic on its rising edge
//   reset_n     : asynchronous active-low reset
//   incr_load   : one-cycle request to load incr_value into channel incr_chan
//   incr_chan   : target channel; values >= CHANNELS are ignored
//   incr_value  : new phase increment
//   phase_sync  : one-cycle request to zero every accumulator
//   clock_out   : generated clock per channel (registered accumulator MSB)
//   clock_en    : one-cycle strobe per channel on each accumulator wrap
//   locked      : configuration stable for LOCK_CYCLES cycles

module multi_clock_nco #(
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 24,
    parameter int LOCK_CYCLES = 16,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] INC_INIT = '0,
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 incr_load,
    input  logic [CHAN_W-1:0]    incr_chan,
    input  logic [ACC_WIDTH-1:0] incr_value,
    input  logic                 phase_sync,
    output logic [CHANNELS-1:0]  clock_out,
    output logic [CHANNELS-1:0]  clock_en,
    output logic                 locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_SETTLE,
        ST_LOCKED
    } lock_state_t;

    logic [ACC_WIDTH-1:0] acc [CHANNELS];
    logic [ACC_WIDTH-1:0] inc [CHANNELS];
    logic [ACC_WIDTH:0]   sum [CHANNELS];

    lock_state_t      state;
    logic [CNT_W-1:0] settle_cnt;
    logic             load_valid;
    logic             restart;

    // The extra leading zero lets CHANNELS itself be represented, so an
    // out-of-range channel number compares correctly for any CHANNELS.
    assign load_valid = incr_load &&
                        ({1'b0, incr_chan} < (CHAN_W + 1)'(CHANNELS));
    assign restart    = load_valid || phase_sync;

    // Per-channel sum with one extra bit; that top bit is the wrap carry.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // Accumulators, increments and the registered clock/strobe outputs.
    // A load updates inc at this edge, so the accumulation at this same edge
    // still uses the old increment. Matching incr_chan against each in-range
    // index means an out-of-range channel simply selects nothing.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                inc[i] <= INC_INIT[i*ACC_WIDTH +: ACC_WIDTH];
            end
            clock_out <= '0;
            clock_en  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (incr_load && (incr_chan == CHAN_W'(i))) begin
                    inc[i] <= incr_value;
                end
                if (phase_sync) begin
                    acc[i]       <= '0;
                    clock_out[i] <= 1'b0;
                    clock_en[i]  <= 1'b0;
                end else begin
                    acc[i]       <= sum[i][ACC_WIDTH-1:0];
                    clock_out[i] <= sum[i][ACC_WIDTH-1];
                    clock_en[i]  <= sum[i][ACC_WIDTH];
                end
            end
        end
    end

    // Lock FSM. The counter value reaching LOCK_CYCLES-1 while in SETTLE means
    // this is the LOCK_CYCLES-th consecutive settle cycle, so locked rises at
    // LOCK_CYCLES+1 edges after reset release. The counter saturates at
    // LOCK_CYCLES and is held there while locked.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RESET;
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                    locked     <= 1'b0;
                end
                ST_SETTLE: begin
                    if (restart) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt >= CNT_W'(LOCK_CYCLES - 1)) begin
                        state      <= ST_LOCKED;
                        settle_cnt <= CNT_W'(LOCK_CYCLES);
                        locked     <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (restart) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        locked     <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_RESET;
                    settle_cnt <= '0;
                    locked     <= 1'b0;
                end
            endcase
        end
    end

endmodule
